// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and defaults for the fetch front end.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int          INSTR_BYTES_DEFAULT  = 4;
  localparam logic [63:0] RESET_VECTOR_DEFAULT = 64'h0;
  localparam int          FETCH_CNT_W          = 32;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-address handshake between the PC stage (master) and the IF/ID register (slave).
interface pc_fetch_unit_if #(
  parameter int BITS = 64
);
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] pc_out;
  logic [BITS-1:0] pc_next_seq;
  logic            squash;

  modport master (
    output out_valid, pc_out, pc_next_seq, squash,
    input  out_ready
  );

  modport slave (
    input  out_valid, pc_out, pc_next_seq, squash,
    output out_ready
  );
endinterface

// File: rtl/pc_fetch_unit_adder.sv
// Generic ripple-carry adder used for the sequential next-PC.
module Adder #(
  parameter int BITS = 64
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            cin,
  output logic [BITS-1:0] sum,
  output logic            cout
);
  logic [BITS:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < BITS; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[BITS];
endmodule

// File: rtl/pc_fetch_unit.sv
// PC stage: holds the fetch PC, handles stall/redirect/halt and the IF/ID handshake.
// Optional alignment check on redirect targets: define PC_ALIGN_CHECK_EN.
//
// state  | meaning
// BOOT   | one cycle after reset, first fetch not yet offered
// RUN    | offering pc_out to IF/ID, advancing on handshake
// HALTED | fetch stopped, waiting for a redirect
module pc_fetch_unit
  import riscv_pipe_pkg::*;
#(
  parameter int              BITS         = 64,
  parameter logic [BITS-1:0] RESET_VECTOR = BITS'(RESET_VECTOR_DEFAULT),
  parameter int              INSTR_BYTES  = INSTR_BYTES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [BITS-1:0]        redirect_target,
  input  logic                   halt_req,
  pc_fetch_unit_if.master        fb,
  output logic [FETCH_CNT_W-1:0] fetch_count,
  output logic                   halted,
  output logic                   misalign_err
);

  fetch_state_t           state_q, state_d;
  logic [BITS-1:0]        pc_q, pc_d;
  logic                   valid_q, valid_d;
  logic                   squash_q, squash_d;
  logic [FETCH_CNT_W-1:0] cnt_q, cnt_d;
  logic [BITS-1:0]        pc_seq;
  logic                   unused_cout;
  logic                   fire;
  logic                   redir_take;
  logic                   redir_bad;
  logic                   mis_q, mis_d;

  // cout is dropped so the PC wraps modulo 2^BITS.
  Adder #(.BITS(BITS)) u_adder (
    .a    (pc_q),
    .b    (BITS'(INSTR_BYTES)),
    .cin  (1'b0),
    .sum  (pc_seq),
    .cout (unused_cout)
  );

  assign fire = valid_q && fb.out_ready && !stall;

`ifdef PC_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = (redirect_target % BITS'(INSTR_BYTES)) != '0;
  assign redir_take = redirect_valid && !mis_q && !misaligned;
  assign redir_bad  = redirect_valid && !mis_q && misaligned;
`else
  assign redir_take = redirect_valid;
  assign redir_bad  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    squash_d = 1'b0;
    cnt_d    = cnt_q;
    mis_d    = mis_q;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b1;
        pc_d    = RESET_VECTOR;
      end
      RUN: begin
        if (fire) cnt_d = cnt_q + 1'b1;
        if (redir_take) begin
          pc_d     = redirect_target;
          valid_d  = 1'b1;
          squash_d = 1'b1;
        end else if (redir_bad) begin
          state_d  = HALTED;
          valid_d  = 1'b0;
          squash_d = 1'b1;
          mis_d    = 1'b1;
        end else if (halt_req) begin
          state_d = HALTED;
          valid_d = 1'b0;
        end else if (fire) begin
          pc_d = pc_seq;
        end
      end
      HALTED: begin
        valid_d = 1'b0;
        if (redir_take) begin
          state_d  = RUN;
          pc_d     = redirect_target;
          valid_d  = 1'b1;
          squash_d = 1'b1;
        end else if (redir_bad) begin
          squash_d = 1'b1;
          mis_d    = 1'b1;
        end
      end
      default: begin
        state_d = BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_VECTOR;
      valid_q  <= 1'b0;
      squash_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      squash_q <= squash_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_d;
  end
  assign misalign_err = mis_q;
`else
  assign mis_q        = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign fb.out_valid   = valid_q;
  assign fb.pc_out      = pc_q;
  assign fb.pc_next_seq = pc_seq;
  assign fb.squash      = squash_q;
  assign fetch_count    = cnt_q;
  assign halted         = (state_q == HALTED);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: 64-bit instance for main behaviour, 8-bit instance for wrap.
module tb_pc_fetch_unit;
  import riscv_pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [63:0] q_a[$];
  logic [63:0] q_b[$];

  // 64-bit instance
  logic        rst, stall, redirect_valid, halt_req;
  logic [63:0] redirect_target;
  logic [31:0] fetch_count;
  logic        halted, misalign_err;
  pc_fetch_unit_if #(.BITS(64)) ifa ();

  pc_fetch_unit #(.BITS(64)) dut_a (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .fb              (ifa),
    .fetch_count     (fetch_count),
    .halted          (halted),
    .misalign_err    (misalign_err)
  );

  // 8-bit instance
  logic        rst8, stall8, redirect8, halt8;
  logic [7:0]  target8;
  logic [31:0] fetch_count8;
  logic        halted8, misalign8;
  pc_fetch_unit_if #(.BITS(8)) ifb ();

  pc_fetch_unit #(.BITS(8)) dut_b (
    .clk             (clk),
    .rst             (rst8),
    .stall           (stall8),
    .redirect_valid  (redirect8),
    .redirect_target (target8),
    .halt_req        (halt8),
    .fb              (ifb),
    .fetch_count     (fetch_count8),
    .halted          (halted8),
    .misalign_err    (misalign8)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && ifa.out_valid && ifa.out_ready && !stall) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fetch_a: unexpected handshake pc %0h expected none", ifa.pc_out);
      end else begin
        chk("fetch_a", ifa.pc_out, q_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst8 && ifb.out_valid && ifb.out_ready && !stall8) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fetch_b: unexpected handshake pc %0h expected none", ifb.pc_out);
      end else begin
        chk("fetch_b", {56'h0, ifb.pc_out}, q_b.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    halt_req = 1'b0; ifa.out_ready = 1'b0;
    rst8 = 1'b1; stall8 = 1'b0; redirect8 = 1'b0; target8 = '0;
    halt8 = 1'b0; ifb.out_ready = 1'b0;
    step(); step();
    chk("rst_pc", ifa.pc_out, 64'h0);
    chk("rst_valid", {63'h0, ifa.out_valid}, 64'h0);
    chk("rst_squash", {63'h0, ifa.squash}, 64'h0);
    chk("rst_cnt", {32'h0, fetch_count}, 64'h0);
    chk("rst_halted", {63'h0, halted}, 64'h0);
    chk("rst_misalign", {63'h0, misalign_err}, 64'h0);

    // BOOT lasts one cycle, then the reset vector is offered
    rst = 1'b0; ifa.out_ready = 1'b1; halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("boot_pc", ifa.pc_out, 64'h0);
    chk("boot_valid", {63'h0, ifa.out_valid}, 64'h1);
    chk("boot_halted", {63'h0, halted}, 64'h0);

    // sequential advance
    for (int i = 0; i < 4; i++) begin
      q_a.push_back(64'(i * 4));
      step();
      chk("seq_pc", ifa.pc_out, 64'((i + 1) * 4));
      chk("seq_squash", {63'h0, ifa.squash}, 64'h0);
      if (i == 2) chk("seq_cnt3", {32'h0, fetch_count}, 64'd3);
    end
    chk("seq_next", ifa.pc_next_seq, 64'h14);

    // stall freezes pc and count even with out_ready
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", ifa.pc_out, 64'h10);
      chk("stall_cnt", {32'h0, fetch_count}, 64'd4);
    end
    stall = 1'b0;
    q_a.push_back(64'h10);
    step();
    chk("unstall_pc", ifa.pc_out, 64'h14);
    chk("unstall_cnt", {32'h0, fetch_count}, 64'd5);

    // redirect with a handshake in the same cycle still counts it
    redirect_valid = 1'b1; redirect_target = 64'h40;
    q_a.push_back(64'h14);
    step();
    chk("redir_pc", ifa.pc_out, 64'h40);
    chk("redir_squash", {63'h0, ifa.squash}, 64'h1);
    chk("redir_cnt", {32'h0, fetch_count}, 64'd6);

    // redirect wins over stall
    stall = 1'b1; redirect_target = 64'h200;
    step();
    chk("redir_stall_pc", ifa.pc_out, 64'h200);
    chk("redir_stall_squash", {63'h0, ifa.squash}, 64'h1);
    chk("redir_stall_valid", {63'h0, ifa.out_valid}, 64'h1);
    chk("redir_stall_cnt", {32'h0, fetch_count}, 64'd6);
    redirect_valid = 1'b0; stall = 1'b0; ifa.out_ready = 1'b0;
    step();
    chk("notready_pc", ifa.pc_out, 64'h200);
    chk("notready_valid", {63'h0, ifa.out_valid}, 64'h1);
    chk("squash_pulse", {63'h0, ifa.squash}, 64'h0);

    // halt with a handshake firing
    redirect_valid = 1'b1; redirect_target = 64'h8;
    step();
    chk("pre_halt_pc", ifa.pc_out, 64'h8);
    redirect_valid = 1'b0; halt_req = 1'b1; ifa.out_ready = 1'b1;
    q_a.push_back(64'h8);
    step();
    chk("halt_cnt", {32'h0, fetch_count}, 64'd7);
    chk("halt_halted", {63'h0, halted}, 64'h1);
    chk("halt_valid", {63'h0, ifa.out_valid}, 64'h0);
    chk("halt_pc", ifa.pc_out, 64'h8);
    step();
    chk("halted_hold_pc", ifa.pc_out, 64'h8);
    chk("halted_hold", {63'h0, halted}, 64'h1);
    chk("halted_squash", {63'h0, ifa.squash}, 64'h0);
    halt_req = 1'b0; ifa.out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_target = 64'h100;
    step();
    chk("resume_halted", {63'h0, halted}, 64'h0);
    chk("resume_pc", ifa.pc_out, 64'h100);
    chk("resume_squash", {63'h0, ifa.squash}, 64'h1);
    chk("resume_valid", {63'h0, ifa.out_valid}, 64'h1);
    redirect_valid = 1'b0;
    step();
    chk("resume_squash_end", {63'h0, ifa.squash}, 64'h0);

    // misaligned redirect
    redirect_valid = 1'b1; redirect_target = 64'h102;
    step();
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_halted", {63'h0, halted}, 64'h1);
    chk("mis_err", {63'h0, misalign_err}, 64'h1);
    chk("mis_pc", ifa.pc_out, 64'h100);
    chk("mis_valid", {63'h0, ifa.out_valid}, 64'h0);
    chk("mis_squash", {63'h0, ifa.squash}, 64'h1);
    redirect_target = 64'h100;
    step();
    chk("mis_ignore_halted", {63'h0, halted}, 64'h1);
    chk("mis_ignore_squash", {63'h0, ifa.squash}, 64'h0);
    chk("mis_sticky", {63'h0, misalign_err}, 64'h1);
`else
    chk("noalign_pc", ifa.pc_out, 64'h102);
    chk("noalign_squash", {63'h0, ifa.squash}, 64'h1);
    chk("noalign_err", {63'h0, misalign_err}, 64'h0);
`endif
    // reset wins over a pending redirect
    rst = 1'b1; redirect_target = 64'h300;
    step();
    chk("rst2_pc", ifa.pc_out, 64'h0);
    chk("rst2_err", {63'h0, misalign_err}, 64'h0);
    chk("rst2_halted", {63'h0, halted}, 64'h0);
    chk("rst2_valid", {63'h0, ifa.out_valid}, 64'h0);
    chk("rst2_cnt", {32'h0, fetch_count}, 64'h0);
    redirect_valid = 1'b0; rst = 1'b0;

    // 8-bit wrap
    rst8 = 1'b0;
    step();
    redirect8 = 1'b1; target8 = 8'hFC;
    step();
    chk("w8_pc", {56'h0, ifb.pc_out}, 64'hFC);
    chk("w8_next", {56'h0, ifb.pc_next_seq}, 64'h00);
    redirect8 = 1'b0; ifb.out_ready = 1'b1;
    q_b.push_back(64'hFC);
    step();
    ifb.out_ready = 1'b0;
    chk("w8_wrap_pc", {56'h0, ifb.pc_out}, 64'h00);
    chk("w8_next2", {56'h0, ifb.pc_next_seq}, 64'h04);
    chk("w8_err", {63'h0, misalign8}, 64'h0);
    chk("w8_cnt", {32'h0, fetch_count8}, 64'd1);

    step();
    chk("queue_a_empty", 64'(q_a.size()), 64'h0);
    chk("queue_b_empty", 64'(q_b.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
